// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants for the UART transmit and receive paths.
//               Holds the frame FSM state encoding, the line levels of the
//               framing bits, the parity type codes and the default payload
//               width.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default payload width; must match the serializer width.
  localparam int UART_DATA_WIDTH = 8;

  // Frame controller state encoding.
  localparam int       STATE_W = 3;
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] PARITY  = 3'd3;
  localparam logic [2:0] STOP    = 3'd4;

  // Line levels.
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Parity type codes, as presented on par_typ.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/parity_calc.sv
`default_nettype none
// ============================================================================
// Module      : parity_calc
// Description : Combinational parity generator. XOR-reduces the payload and
//               folds in the parity type so the result is the bit that makes
//               the total number of ones even (type 0) or odd (type 1).
//               Shared by the TX frame controller and the RX parity check.
// Ports       : i_data     [WIDTH-1:0] payload
//               i_par_typ  parity type, 0 = even, 1 = odd
//               o_par_bit  parity bit to transmit / expect
// Revision    : 1.0 - initial release
// ============================================================================
module parity_calc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_par_typ,
  output logic             o_par_bit
);

  assign o_par_bit = (^i_data) ^ i_par_typ;

endmodule : parity_calc
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : UART transmit frame controller. Sequences START, DATA,
//               optional PARITY and STOP, drives the serializer through the
//               ser_en / busy / ser_dn handshake and multiplexes the framing
//               bits, serial data and parity bit onto the TX line. Aborts a
//               frame that stalls in DATA and flags it on tx_err.
// Ports       : clk         system clock, rising edge
//               rst         asynchronous active-low reset
//               P_data      [DATA_WIDTH-1:0] byte to send, sampled in IDLE
//               data_valid  send request
//               par_en      1 = append parity bit (sampled with data_valid)
//               par_typ     0 = even, 1 = odd (sampled with data_valid)
//               ser_data    registered serial bit from the serializer
//               ser_dn      serializer done (last data bit on ser_data)
//               ser_en      shift enable to the serializer
//               busy        frame in progress / serializer load gate
//               tx_out      UART line, idle high
//               tx_err      one-cycle pulse on DATA timeout abort
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int DATA_TIMEOUT = DATA_WIDTH + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  ser_data,
  input  logic                  ser_dn,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  tx_out,
  output logic                  tx_err
);

  localparam int CNT_W = $clog2(DATA_TIMEOUT + 1);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic               r_par_en_q;
  logic               r_par_bit_q;
  logic [CNT_W-1:0]   r_tmo_cnt;
  logic               r_tx_err;
  logic               w_par_bit;
  logic               w_accept;
  logic               w_timeout;

  parity_calc #(
    .WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .i_data    (P_data),
    .i_par_typ (par_typ),
    .o_par_bit (w_par_bit)
  );

  // A request is only honoured in IDLE; anywhere else it is dropped.
  assign w_accept = (r_state == IDLE) && data_valid;

  // The counter holds the number of DATA cycles already completed, so the
  // abort fires in the DATA_TIMEOUT-th DATA cycle if ser_dn never came.
  assign w_timeout = (r_state == DATA) && !ser_dn &&
                     (r_tmo_cnt == CNT_W'(DATA_TIMEOUT - 1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (data_valid) begin
          w_next_state = START;
        end
      end
      START: begin
        w_next_state = DATA;
      end
      DATA: begin
        if (ser_dn) begin
          w_next_state = r_par_en_q ? PARITY : STOP;
        end else if (w_timeout) begin
          // Skip parity so the line still finishes on a stop bit.
          w_next_state = STOP;
        end
      end
      PARITY: begin
        w_next_state = STOP;
      end
      STOP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode. tx_out depends only on the state register and registered
  // sources, so no input ever reaches the pin combinationally.
  // --------------------------------------------------------------------------
  always_comb begin
    tx_out = IDLE_LEVEL;
    busy   = 1'b0;
    ser_en = 1'b0;
    case (r_state)
      START: begin
        tx_out = START_BIT;
        busy   = 1'b1;
        ser_en = 1'b1;
      end
      DATA: begin
        tx_out = ser_data;
        busy   = 1'b1;
        ser_en = 1'b1;
      end
      PARITY: begin
        tx_out = r_par_bit_q;
        busy   = 1'b1;
      end
      STOP: begin
        // busy high with ser_en low clears the serializer count and ser_dn.
        tx_out = STOP_BIT;
        busy   = 1'b1;
      end
      default: begin
        tx_out = IDLE_LEVEL;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame options, timeout counter and error pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_en_q  <= 1'b0;
      r_par_bit_q <= 1'b0;
    end else if (w_accept) begin
      r_par_en_q  <= par_en;
      r_par_bit_q <= w_par_bit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == DATA) && (w_next_state == DATA)) begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_err <= 1'b0;
    end else begin
      r_tx_err <= w_timeout;
    end
  end

  assign tx_err = r_tx_err;

endmodule : uart_tx_ctrl
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Self-checking bench for uart_tx_ctrl. Contains a serializer
//               model, a frame-level expectation model that turns each
//               accepted request into the list of per-cycle line/handshake
//               values, a per-cycle compare process, and directed frames with
//               hand-computed line sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] P_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       ser_data;
  logic       ser_dn;
  logic       ser_en;
  logic       busy;
  logic       tx_out;
  logic       tx_err;
  logic       stuck;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_ctrl #(
    .DATA_WIDTH   (8),
    .DATA_TIMEOUT (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .P_data     (P_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .ser_data   (ser_data),
    .ser_dn     (ser_dn),
    .ser_en     (ser_en),
    .busy       (busy),
    .tx_out     (tx_out),
    .tx_err     (tx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Serializer model: loads while busy is low, shifts LSB first on ser_en,
  // raises done while the last bit is presented, clears on busy & !ser_en.
  // ----------------------------------------------------------------------------
  logic [7:0] s_sh;
  logic [3:0] s_cnt;
  logic       s_bit;
  logic       s_dn;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_sh  <= 8'h00;
      s_cnt <= 4'd0;
      s_bit <= 1'b0;
      s_dn  <= 1'b0;
    end else if (!busy) begin
      s_sh  <= P_data;
      s_cnt <= 4'd0;
      s_dn  <= 1'b0;
    end else if (ser_en) begin
      s_bit <= s_sh[0];
      s_sh  <= {1'b0, s_sh[7:1]};
      s_cnt <= s_cnt + 4'd1;
      s_dn  <= (s_cnt == 4'd7);
    end else begin
      s_cnt <= 4'd0;
      s_dn  <= 1'b0;
    end
  end

  assign ser_data = s_bit;
  assign ser_dn   = s_dn & ~stuck;

  // --------------------------------------------------------------------------
  // Frame-level model: a queue of expected {tx_out, busy, ser_en, tx_err}.
  // ----------------------------------------------------------------------------
  typedef struct packed {
    logic tx;
    logic bsy;
    logic en;
    logic err;
  } exp_t;

  exp_t q[$];
  int   left = 0;

  function automatic void build_frame(input logic [7:0] d, input logic pe,
                                      input logic pt, input logic stk);
    exp_t e;
    e = '{tx: 1'b0, bsy: 1'b1, en: 1'b1, err: 1'b0};
    q.push_back(e);
    if (stk) begin
      // Ten DATA cycles: the eight payload bits, then zeros shifted in.
      for (int i = 0; i < 10; i++) begin
        e = '{tx: (i < 8) ? d[i] : 1'b0, bsy: 1'b1, en: 1'b1, err: 1'b0};
        q.push_back(e);
      end
      e = '{tx: 1'b1, bsy: 1'b1, en: 1'b0, err: 1'b1};
      q.push_back(e);
      left = 12;
    end else begin
      for (int i = 0; i < 8; i++) begin
        e = '{tx: d[i], bsy: 1'b1, en: 1'b1, err: 1'b0};
        q.push_back(e);
      end
      if (pe) begin
        e = '{tx: (^d) ^ pt, bsy: 1'b1, en: 1'b0, err: 1'b0};
        q.push_back(e);
      end
      e = '{tx: 1'b1, bsy: 1'b1, en: 1'b0, err: 1'b0};
      q.push_back(e);
      left = pe ? 11 : 10;
    end
  endfunction

  // Per-cycle compare, then advance the model across the coming edge.
  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    e   = '{tx: 1'b1, bsy: 1'b0, en: 1'b0, err: 1'b0};
    got = '{tx: tx_out, bsy: busy, en: ser_en, err: tx_err};
    if (!rst) begin
      q.delete();
      left = 0;
    end else if (q.size() > 0) begin
      e = q.pop_front();
    end
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL cycle_model t=%0t tx/busy/en/err got %b%b%b%b want %b%b%b%b",
               $time, got.tx, got.bsy, got.en, got.err, e.tx, e.bsy, e.en, e.err);
    end
    if (rst) begin
      if (left > 0) begin
        left--;
      end else if (data_valid) begin
        build_frame(P_data, par_en, par_typ, stuck);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed helpers
  // ----------------------------------------------------------------------------
  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  // Entered at posedge+2; leaves at posedge+2 of the START cycle.
  task automatic pulse(input logic [7:0] d, input logic pe, input logic pt);
    P_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    @(posedge clk);
    #2;
    data_valid = 1'b0;
    par_en     = ~pe;
    par_typ    = ~pt;
  endtask

  // Records n cycles starting with the current one; optionally re-requests
  // 0x3C in cycles inj_a / inj_b.
  task automatic capture(input int n, input int inj_a, input int inj_b,
                         output logic [15:0] cap, output int nb, output int ne,
                         output int nerr, output int erri);
    cap  = '0;
    nb   = 0;
    ne   = 0;
    nerr = 0;
    erri = -1;
    for (int i = 0; i < n; i++) begin
      if (i == inj_a || i == inj_b) begin
        P_data     = 8'h3C;
        data_valid = 1'b1;
      end else begin
        data_valid = 1'b0;
      end
      #4;
      cap[i] = tx_out;
      nb += int'(busy);
      ne += int'(ser_en);
      if (tx_err) begin
        nerr++;
        erri = i;
      end
      @(posedge clk);
      #2;
    end
    data_valid = 1'b0;
  endtask

  logic [15:0] cap;
  int nb, ne, nerr, erri, bad_idle;

  initial begin
    rst        = 1'b0;
    P_data     = 8'h00;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    stuck      = 1'b0;

    // Reset and quiet idle line.
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("reset_tx_out", int'(tx_out), 1);
    check("reset_busy",   int'(busy),   0);
    check("reset_ser_en", int'(ser_en), 0);
    check("reset_tx_err", int'(tx_err), 0);
    #1;
    bad_idle = 0;
    for (int i = 0; i < 20; i++) begin
      #4;
      if (tx_out !== 1'b1 || busy !== 1'b0 || ser_en !== 1'b0 || tx_err !== 1'b0)
        bad_idle++;
      @(posedge clk);
      #2;
    end
    check("idle_20_cycles", bad_idle, 0);

    // 0xA5, no parity.
    pulse(8'hA5, 1'b0, 1'b0);
    capture(12, -1, -1, cap, nb, ne, nerr, erri);
    check("a5_line",   int'(cap[11:0]), 12'b111101001010);
    check("a5_busy",   nb, 10);
    check("a5_ser_en", ne, 9);

    // 0x07, even parity -> parity bit 1.
    pulse(8'h07, 1'b1, 1'b0);
    capture(12, -1, -1, cap, nb, ne, nerr, erri);
    check("07_even_line", int'(cap[11:0]), 12'b111000001110);
    check("07_even_busy", nb, 11);
    check("07_even_en",   ne, 9);

    // 0xA5, odd parity -> parity bit 1.
    pulse(8'hA5, 1'b1, 1'b1);
    capture(12, -1, -1, cap, nb, ne, nerr, erri);
    check("a5_odd_parity_bit", int'(cap[9]), 1);
    check("a5_odd_busy",       nb, 11);

    // Requests in DATA and in STOP are dropped.
    pulse(8'hA5, 1'b0, 1'b0);
    capture(14, 4, 9, cap, nb, ne, nerr, erri);
    check("reject_line", int'(cap[13:0]), 14'b11111101001010);
    check("reject_busy", nb, 10);

    // A fresh request in IDLE is served.
    pulse(8'h3C, 1'b0, 1'b0);
    capture(12, -1, -1, cap, nb, ne, nerr, erri);
    check("3c_line", int'(cap[11:0]), 12'b111001111000);

    // Stalled serializer: abort after ten DATA cycles.
    stuck = 1'b1;
    pulse(8'hA5, 1'b1, 1'b0);
    capture(14, -1, -1, cap, nb, ne, nerr, erri);
    stuck = 1'b0;
    check("tmo_err_count", nerr, 1);
    check("tmo_err_cycle", erri, 11);
    check("tmo_stop_high", int'(cap[11]), 1);
    check("tmo_busy",      nb, 12);

    // Reset in the fourth DATA cycle.
    pulse(8'hA5, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_tx_out", int'(tx_out), 1);
    check("midreset_busy",   int'(busy),   0);
    check("midreset_ser_en", int'(ser_en), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    pulse(8'h07, 1'b1, 1'b0);
    capture(12, -1, -1, cap, nb, ne, nerr, erri);
    check("after_reset_line", int'(cap[11:0]), 12'b111000001110);
    check("after_reset_busy", nb, 11);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_uart_tx_ctrl
`default_nettype wire
